// File: rtl/sdram_pkg.sv
// sdram_pkg: shared constants and types for the SDRAM controller read path.
// SDRAM command encodings, pin/bus widths and the read-engine state enum.
package sdram_pkg;

    localparam int ADDR_W  = 12;
    localparam int BA_W    = 2;
    localparam int DQ_W    = 16;
    localparam int ROW_W   = 12;
    localparam int COL_W   = 8;
    localparam int RADDR_W = BA_W + ROW_W + COL_W;

    // Address pin carrying the precharge-all / auto-precharge flag.
    localparam int A10_BIT = 10;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;

    typedef enum logic [3:0] {
        IDLE,
        ACT,
        TRCD_WAIT,
        RD,
        BURST,
        PRE,
        TRP_WAIT,
        DRAIN,
        DONE
    } rd_state_e;

endpackage

// File: rtl/sdram_read_if.sv
// sdram_read_if: request/grant, command pins and read-data bundle of the
// SDRAM burst-read engine.
//
// Handshake: rd_req is a level request held by the client until rd_done;
// rd_en is the arbiter grant and is only looked at while the engine is idle.
// A transaction starts on a cycle where rd_req && rd_en are both high in
// IDLE; rd_addr is captured on that cycle. rd_data_vld strobes once per
// burst word with rd_data, and rd_done pulses once when the row is closed
// and all data has been delivered. There is no backpressure on read data.
interface sdram_read_if;
    import sdram_pkg::*;

    logic               rd_req;
    logic               rd_en;
    logic [RADDR_W-1:0] rd_addr;
    logic [3:0]         cmd;
    logic [BA_W-1:0]    ba;
    logic [ADDR_W-1:0]  addr;
    logic [DQ_W-1:0]    dq;
    logic [DQ_W-1:0]    rd_data;
    logic               rd_data_vld;
    logic               rd_busy;
    logic               rd_done;

    // Client/arbiter/pin side.
    modport master (
        output rd_req, rd_en, rd_addr, dq,
        input  cmd, ba, addr, rd_data, rd_data_vld, rd_busy, rd_done
    );

    // Read engine side.
    modport slave (
        input  rd_req, rd_en, rd_addr, dq,
        output cmd, ba, addr, rd_data, rd_data_vld, rd_busy, rd_done
    );

endinterface

// File: rtl/sdram_rd_capture.sv
// sdram_rd_capture: turns the command-side burst window into data strobes.
// A delay line of CAS_LAT stages marks which Dq cycles carry burst words;
// the marked word is sampled on the edge that ends its data cycle.
// Optional macro SDRAM_RD_DQ_REG_EN adds an input flop on dq (IOB register),
// lengthening the delay line by one so the strobes move one cycle later.
module sdram_rd_capture
    import sdram_pkg::*;
#(
    parameter int CAS_LAT = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            burst_win,
    input  logic [DQ_W-1:0] dq,
    output logic [DQ_W-1:0] rd_data,
    output logic            rd_data_vld,
    output logic            pending
);

    logic [DQ_W-1:0] dq_src;

`ifdef SDRAM_RD_DQ_REG_EN
    localparam int DEPTH = CAS_LAT + 1;

    logic [DQ_W-1:0] dq_q;

    // Pad-side register on the data pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dq_q <= '0;
        else        dq_q <= dq;
    end

    assign dq_src = dq_q;
`else
    localparam int DEPTH = CAS_LAT;

    assign dq_src = dq;
`endif

    logic [DEPTH-1:0] mark_q;

    // Delay line: a bit entering here lines up with its word DEPTH cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mark_q <= '0;
        else        mark_q <= {mark_q[DEPTH-2:0], burst_win};
    end

    // Capture the marked word; rd_data keeps the last word between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data     <= '0;
            rd_data_vld <= 1'b0;
        end else begin
            rd_data_vld <= mark_q[DEPTH-1];
            if (mark_q[DEPTH-1]) rd_data <= dq_src;
        end
    end

    // Words still travelling through the delay line.
    assign pending = |mark_q;

endmodule

// File: rtl/sdram_read.sv
// sdram_read: burst-read engine. On grant it issues ACTIVE, READ and
// PRECHARGE (all banks) with TRCD/TRP spacing, collects BURST_LEN words via
// sdram_rd_capture and pulses rd_done once the row is closed and the last
// word has been strobed. Command pins are registered from the next state so
// cmd/ba/addr line up with the state they belong to.
// Optional macro SDRAM_RD_DQ_REG_EN (see sdram_rd_capture) delays the data
// window and rd_done by one cycle; command timing is unaffected.
module sdram_read
    import sdram_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int CAS_LAT   = 3,
    parameter int TRCD      = 2,
    parameter int TRP       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    sdram_read_if.slave bus,
    output rd_state_e  state_dbg
);

    localparam int CNT_W = 8;

    rd_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RADDR_W-1:0] raddr_q, raddr_d;

    logic [3:0]         cmd_q, cmd_d;
    logic [BA_W-1:0]    ba_q, ba_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               busy_q, done_q;

    logic               burst_win;
    logic               pending;
    logic [DQ_W-1:0]    rd_data_w;
    logic               rd_data_vld_w;

    // Next state, wait counter, captured address and next command pins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        raddr_d = raddr_q;

        case (state_q)
            IDLE: begin
                if (bus.rd_req && bus.rd_en) begin
                    raddr_d = bus.rd_addr;
                    state_d = ACT;
                end
            end
            ACT: begin
                if (TRCD > 1) begin
                    cnt_d   = CNT_W'(TRCD - 2);
                    state_d = TRCD_WAIT;
                end else begin
                    state_d = RD;
                end
            end
            TRCD_WAIT: begin
                if (cnt_q == '0) state_d = RD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RD: begin
                if (BURST_LEN > 1) begin
                    cnt_d   = CNT_W'(BURST_LEN - 2);
                    state_d = BURST;
                end else begin
                    state_d = PRE;
                end
            end
            BURST: begin
                if (cnt_q == '0) state_d = PRE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            PRE: begin
                if (TRP > 1) begin
                    cnt_d   = CNT_W'(TRP - 2);
                    state_d = TRP_WAIT;
                end else begin
                    state_d = DRAIN;
                end
            end
            TRP_WAIT: begin
                if (cnt_q == '0) state_d = DRAIN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DRAIN: begin
                if (!pending) state_d = DONE;
            end
            DONE: begin
                // A still-high rd_req needs a fresh grant seen from IDLE.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cmd_d  = CMD_NOP;
        ba_d   = '0;
        addr_d = '0;
        case (state_d)
            ACT: begin
                cmd_d  = CMD_ACTIVE;
                ba_d   = raddr_d[RADDR_W-1 -: BA_W];
                addr_d = raddr_d[COL_W +: ROW_W];
            end
            RD: begin
                // A10 stays low: the row is closed by an explicit PRECHARGE.
                cmd_d  = CMD_READ;
                ba_d   = raddr_d[RADDR_W-1 -: BA_W];
                addr_d = {{(ADDR_W-COL_W){1'b0}}, raddr_d[COL_W-1:0]};
            end
            PRE: begin
                cmd_d           = CMD_PRECHARGE;
                addr_d[A10_BIT] = 1'b1;
            end
            default: ;
        endcase
    end

    // State, counter, address and registered pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            raddr_q <= '0;
            cmd_q   <= CMD_NOP;
            ba_q    <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            raddr_q <= raddr_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    // The READ cycle plus the following BURST_LEN-1 cycles map one-to-one
    // onto the burst words, CAS_LAT cycles later on Dq.
    assign burst_win = (state_q == RD) || (state_q == BURST);

    sdram_rd_capture #(
        .CAS_LAT (CAS_LAT)
    ) u_capture (
        .clk         (clk),
        .rst_n       (rst_n),
        .burst_win   (burst_win),
        .dq          (bus.dq),
        .rd_data     (rd_data_w),
        .rd_data_vld (rd_data_vld_w),
        .pending     (pending)
    );

    assign bus.cmd         = cmd_q;
    assign bus.ba          = ba_q;
    assign bus.addr        = addr_q;
    assign bus.rd_data     = rd_data_w;
    assign bus.rd_data_vld = rd_data_vld_w;
    assign bus.rd_busy     = busy_q;
    assign bus.rd_done     = done_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_sdram_read.sv
// tb_sdram_read: two engines (defaults, and CAS_LAT=2/BURST_LEN=8) driven in
// lockstep with random addresses and random Dq words, checked cycle by cycle
// against a timeline computed from the command/latency rules.
// Honors SDRAM_RD_DQ_REG_EN the same way as the RTL build.
module tb_sdram_read;
    import sdram_pkg::*;

`ifdef SDRAM_RD_DQ_REG_EN
    localparam int DQR = 1;
`else
    localparam int DQR = 0;
`endif
    localparam int BL0    = 4;
    localparam int CL0    = 3;
    localparam int BL1    = 8;
    localparam int CL1    = 2;
    localparam int TRCD_P = 2;
    localparam int TRP_P  = 2;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [11:0] addr;
        logic [15:0] data;
        logic        vld;
        logic        busy;
        logic        done;
        logic [3:0]  st;
    } obs_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdram_read_if if0();
    sdram_read_if if1();
    rd_state_e    st0, st1;

    sdram_read dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if0),
        .state_dbg (st0)
    );

    sdram_read #(
        .BURST_LEN (BL1),
        .CAS_LAT   (CL1),
        .TRCD      (TRCD_P),
        .TRP       (TRP_P)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if1),
        .state_dbg (st1)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [15:0] last_word[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    // ---------------- reference timeline ----------------
    function automatic int p_bl(input int i);
        return (i == 0) ? BL0 : BL1;
    endfunction
    function automatic int p_cl(input int i);
        return (i == 0) ? CL0 : CL1;
    endfunction
    function automatic int t_rd(input int i);
        return (i == 0) ? 1 + TRCD_P : 1 + TRCD_P;
    endfunction
    function automatic int t_pre(input int i);
        return t_rd(i) + p_bl(i);
    endfunction
    function automatic int t_dq0(input int i);
        return t_rd(i) + p_cl(i);
    endfunction
    function automatic int t_vld0(input int i);
        return t_dq0(i) + 1 + DQR;
    endfunction
    function automatic int t_vld1(input int i);
        return t_vld0(i) + p_bl(i) - 1;
    endfunction
    function automatic int t_done(input int i);
        int a;
        int b;
        a = t_vld1(i);
        b = t_pre(i) + TRP_P;
        return ((a > b) ? a : b) + 1;
    endfunction

    // ---------------- driver helpers ----------------
    function automatic obs_t snap(input int i);
        obs_t o;
        o.cmd  = (i == 0) ? if0.cmd         : if1.cmd;
        o.ba   = (i == 0) ? if0.ba          : if1.ba;
        o.addr = (i == 0) ? if0.addr        : if1.addr;
        o.data = (i == 0) ? if0.rd_data     : if1.rd_data;
        o.vld  = (i == 0) ? if0.rd_data_vld : if1.rd_data_vld;
        o.busy = (i == 0) ? if0.rd_busy     : if1.rd_busy;
        o.done = (i == 0) ? if0.rd_done     : if1.rd_done;
        o.st   = (i == 0) ? st0             : st1;
        return o;
    endfunction

    task automatic set_in(input logic req, input logic en, input logic [21:0] a);
        if0.rd_req  = req;
        if1.rd_req  = req;
        if0.rd_en   = en;
        if1.rd_en   = en;
        if0.rd_addr = a;
        if1.rd_addr = a;
    endtask

    task automatic drive_dq(input int i, input logic [15:0] w);
        if (i == 0) if0.dq = w;
        else        if1.dq = w;
    endtask

    task automatic check_quiet(input int i, input string pfx);
        obs_t o;
        o = snap(i);
        check({pfx, "_cmd"},  32'(o.cmd),  32'(CMD_NOP));
        check({pfx, "_ba"},   32'(o.ba),   32'd0);
        check({pfx, "_addr"}, 32'(o.addr), 32'd0);
        check({pfx, "_vld"},  32'(o.vld),  32'd0);
        check({pfx, "_busy"}, 32'(o.busy), 32'd0);
        check({pfx, "_done"}, 32'(o.done), 32'd0);
        check({pfx, "_data"}, 32'(o.data), 32'(last_word[i]));
        check({pfx, "_st"},   32'(o.st),   32'(IDLE));
    endtask

    task automatic idle(input int n, input logic req);
        set_in(req, 1'b0, 22'($urandom));
        repeat (n) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                check_quiet(i, "idle");
                drive_dq(i, 16'($urandom));
            end
        end
    endtask

    task automatic check_cycle(input int i, input int c, input logic [21:0] a);
        obs_t        o;
        logic [3:0]  ec;
        logic [15:0] w;
        int          qn;
        bit          in_vld;
        o      = snap(i);
        in_vld = (c >= t_vld0(i)) && (c <= t_vld1(i));
        ec     = (c == 1)        ? CMD_ACTIVE :
                 (c == t_rd(i))  ? CMD_READ :
                 (c == t_pre(i)) ? CMD_PRECHARGE : CMD_NOP;
        check("cmd", 32'(o.cmd), 32'(ec));
        if (ec == CMD_ACTIVE) begin
            check("act_ba",  32'(o.ba),   32'(a[21:20]));
            check("act_row", 32'(o.addr), 32'(a[19:8]));
        end else if (ec == CMD_READ) begin
            check("rd_ba",  32'(o.ba),   32'(a[21:20]));
            check("rd_col", 32'(o.addr), 32'(a[7:0]));
        end else if (ec == CMD_PRECHARGE) begin
            check("pre_a10", 32'(o.addr[10]), 32'd1);
        end else begin
            check("nop_ba",   32'(o.ba),   32'd0);
            check("nop_addr", 32'(o.addr), 32'd0);
        end
        check("busy", 32'(o.busy), 32'(c >= 1 && c <= t_done(i)));
        check("done", 32'(o.done), 32'(c == t_done(i)));
        check("vld",  32'(o.vld),  32'(in_vld));
        if (in_vld) begin
            qn = (i == 0) ? exp_q0.size() : exp_q1.size();
            check("exp_q_nonempty", 32'(qn > 0), 32'd1);
            if (qn > 0) begin
                w = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check("rd_data", 32'(o.data), 32'(w));
                last_word[i] = w;
            end
        end else begin
            check("rd_data_hold", 32'(o.data), 32'(last_word[i]));
        end
    endtask

    task automatic reset_mid;
        obs_t o;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            o = snap(i);
            check("rst_cmd",  32'(o.cmd),  32'(CMD_NOP));
            check("rst_vld",  32'(o.vld),  32'd0);
            check("rst_busy", 32'(o.busy), 32'd0);
            check("rst_done", 32'(o.done), 32'd0);
            check("rst_data", 32'(o.data), 32'd0);
        end
        exp_q0.delete();
        exp_q1.delete();
        last_word[0] = '0;
        last_word[1] = '0;
        set_in(1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle(10, 1'b0);
    endtask

    // One granted transaction on both engines; en_len = cycles rd_en stays high
    // from the grant cycle; rst_at > 0 asserts reset at that cycle instead.
    task automatic run_txn(input logic [21:0] a, input int en_len, input bit fixed, input int rst_at);
        int          tmax;
        int          k;
        logic [15:0] w;
        tmax = (t_done(0) > t_done(1)) ? t_done(0) : t_done(1);
        set_in(1'b1, 1'b1, a);
        drive_dq(0, 16'($urandom));
        drive_dq(1, 16'($urandom));
        for (int c = 1; c <= tmax + 2; c++) begin
            @(posedge clk); #1;
            if (c == rst_at) begin
                reset_mid();
                return;
            end
            for (int i = 0; i < 2; i++) check_cycle(i, c, a);
            set_in(c <= tmax, c < en_len, 22'($urandom));
            for (int i = 0; i < 2; i++) begin
                if (c >= t_dq0(i) && c < t_dq0(i) + p_bl(i)) begin
                    k = c - t_dq0(i);
                    w = fixed ? 16'(16'h1111 * (k + 1)) : 16'($urandom);
                    if (i == 0) exp_q0.push_back(w);
                    else        exp_q1.push_back(w);
                    drive_dq(i, w);
                end else begin
                    drive_dq(i, 16'($urandom));
                end
            end
        end
        check("left_q0", 32'(exp_q0.size()), 32'd0);
        check("left_q1", 32'(exp_q1.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, '0);
        if0.dq = '0;
        if1.dq = '0;
        last_word[0] = '0;
        last_word[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check_quiet(i, "reset");
        @(negedge clk) rst_n = 1'b1;

        idle(2, 1'b0);
        run_txn(22'h2ABC12, 1, 1'b1, -1);

        idle(5, 1'b1);
        run_txn(22'($urandom), 1, 1'b0, -1);

        idle(1, 1'b0);
        run_txn(22'($urandom), 4, 1'b0, -1);

        idle(1, 1'b0);
        run_txn(22'($urandom), 1, 1'b0, 8);
        run_txn(22'($urandom), 1, 1'b0, -1);

        for (int n = 0; n < 6; n++) begin
            idle($urandom_range(1, 4), 1'($urandom_range(0, 1)));
            run_txn(22'($urandom), $urandom_range(1, 4), 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
